// File: rtl/dump_seq_pkg.sv
// Shared types and constants for the receiver-protection dump sequencer.
package dump_seq_pkg;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_NUM_W   = 8;
  localparam int PWRUP_DELAY = 1;
  localparam int PWRUP_WIDTH = 19;
  localparam int PWRUP_GAP   = 1;
  localparam int PWRUP_NUM   = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_ON    = 2'd2,
    ST_GAP   = 2'd3
  } state_t;
endpackage

// File: rtl/dump_timer.sv
// Loadable down-counter with zero flag; load wins over decrement, holds at zero.
module dump_timer #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/dump_sequencer.sv
// Dump pulse train scheduler: delay, then num pulses of width separated by gap.
// Optional DUMP_POWERUP_EN: one silent self-run train after reset release.
//
// state    | meaning
// ST_IDLE  | waiting for start (or pending power-up train)
// ST_DELAY | counting initial delay before first pulse
// ST_ON    | dumpon high for latched width
// ST_GAP   | dumpon low between pulses
module dump_sequencer
  import dump_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int NUM_W = DEF_NUM_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_cfg_delay,
  input  logic [CNT_W-1:0] i_cfg_width,
  input  logic [CNT_W-1:0] i_cfg_gap,
  input  logic [NUM_W-1:0] i_cfg_num,
  input  logic             i_clr_overrun,
  output logic             o_dumpon,
  output logic             o_busy,
  output logic             o_done,
  output logic [NUM_W-1:0] o_pulse_idx,
  output logic             o_overrun
);
`ifdef DUMP_POWERUP_EN
  localparam logic PWRUP_EN = 1'b1;
`else
  localparam logic PWRUP_EN = 1'b0;
`endif

  state_t           r_state;
  logic             r_dumpon;
  logic             r_busy;
  logic             r_done;
  logic [NUM_W-1:0] r_idx;
  logic             r_overrun;
  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] r_gap;
  logic [NUM_W-1:0] r_num;
  logic             r_silent;
  logic             r_pwrup_pend;

  state_t           w_state_n;
  logic             w_done_n;
  logic [NUM_W-1:0] w_idx_n;
  logic             w_latch;
  logic             w_latch_pwrup;
  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_val;
  logic             w_tmr_en;
  logic             w_tmr_zero;
  logic             w_last;
  logic [CNT_W-1:0] w_width_m1;
  logic [CNT_W-1:0] w_gap_m1;

  // Zero width/gap behave as one cycle; timer terminal count is zero.
  assign w_width_m1 = (r_width == '0) ? '0 : r_width - 1'b1;
  assign w_gap_m1   = (r_gap == '0) ? '0 : r_gap - 1'b1;
  assign w_last     = (r_idx == r_num - NUM_W'(1));

  dump_timer #(.W(CNT_W)) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_zero     (w_tmr_zero)
  );

  always_comb begin
    w_state_n     = r_state;
    w_done_n      = 1'b0;
    w_idx_n       = r_idx;
    w_latch       = 1'b0;
    w_latch_pwrup = 1'b0;
    w_tmr_load    = 1'b0;
    w_tmr_val     = '0;
    w_tmr_en      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!i_abort) begin
          if (r_pwrup_pend) begin
            w_latch_pwrup = 1'b1;
            w_idx_n       = '0;
            w_state_n     = ST_DELAY;
            w_tmr_load    = 1'b1;
            w_tmr_val     = CNT_W'(PWRUP_DELAY);
          end else if (i_start) begin
            w_latch = 1'b1;
            w_idx_n = '0;
            if (i_cfg_num == '0) begin
              w_done_n = 1'b1;
            end else begin
              w_state_n  = ST_DELAY;
              w_tmr_load = 1'b1;
              w_tmr_val  = i_cfg_delay;
            end
          end
        end
      end
      ST_DELAY: begin
        if (i_abort) begin
          w_state_n = ST_IDLE;
        end else if (w_tmr_zero) begin
          w_state_n  = ST_ON;
          w_tmr_load = 1'b1;
          w_tmr_val  = w_width_m1;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      ST_ON: begin
        if (i_abort) begin
          w_state_n = ST_IDLE;
        end else if (w_tmr_zero) begin
          if (w_last) begin
            w_state_n = ST_IDLE;
            w_done_n  = !r_silent;
          end else begin
            w_state_n  = ST_GAP;
            w_tmr_load = 1'b1;
            w_tmr_val  = w_gap_m1;
          end
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      ST_GAP: begin
        if (i_abort) begin
          w_state_n = ST_IDLE;
        end else if (w_tmr_zero) begin
          w_state_n  = ST_ON;
          w_idx_n    = r_idx + NUM_W'(1);
          w_tmr_load = 1'b1;
          w_tmr_val  = w_width_m1;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_dumpon <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_idx    <= '0;
    end else begin
      r_state  <= w_state_n;
      r_dumpon <= (w_state_n == ST_ON);
      r_busy   <= (w_state_n != ST_IDLE);
      r_done   <= w_done_n;
      r_idx    <= w_idx_n;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_width  <= '0;
      r_gap    <= '0;
      r_num    <= '0;
      r_silent <= 1'b0;
    end else if (w_latch) begin
      r_width  <= i_cfg_width;
      r_gap    <= i_cfg_gap;
      r_num    <= i_cfg_num;
      r_silent <= 1'b0;
    end else if (w_latch_pwrup) begin
      r_width  <= CNT_W'(PWRUP_WIDTH);
      r_gap    <= CNT_W'(PWRUP_GAP);
      r_num    <= NUM_W'(PWRUP_NUM);
      r_silent <= 1'b1;
    end
  end

  // The power-up request is consumed on the first IDLE cycle, launched or aborted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pwrup_pend <= PWRUP_EN;
      r_overrun    <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) r_pwrup_pend <= 1'b0;
      if (i_start && ((r_state != ST_IDLE) || r_pwrup_pend)) begin
        r_overrun <= 1'b1;
      end else if (i_clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_dumpon    = r_dumpon;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pulse_idx = r_idx;
  assign o_overrun   = r_overrun;
endmodule
